// File: rtl/exu_pipe_ctrl.sv
// EX1->EX2 segment hazard and sequencing controller.
// Produces segment hold/bubble, upstream IF/ID stall/flush, MDU start/kill with a
// watchdog, and a saturating stall-cycle counter. Pure control, no datapath.
module exu_pipe_ctrl #(
    parameter int unsigned REG_IDX_W   = 5,
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned PERF_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_ex1_valid,
    input  logic                 i_ex1_is_mdu,
    input  logic                 i_ex1_use_rs1,
    input  logic                 i_ex1_use_rs2,
    input  logic [REG_IDX_W-1:0] i_ex1_rs1,
    input  logic [REG_IDX_W-1:0] i_ex1_rs2,
    input  logic                 i_ex2_valid,
    input  logic [REG_IDX_W-1:0] i_ex2_rd,
    input  logic                 i_ex2_write_gpr,
    input  logic                 i_ex2_mem_to_reg,
    input  logic                 i_ex2_branch_taken,
    input  logic                 i_mem_ready,
    input  logic                 i_mdu_ready,
    input  logic                 i_mdu_done,
    output logic                 o_stall_if_id,
    output logic                 o_stall_ex1,
    output logic                 o_stall_ex2,
    output logic                 o_flush_ex1,
    output logic                 o_flush_id,
    output logic                 o_mdu_start,
    output logic                 o_mdu_kill,
    output logic                 o_mdu_timeout_err,
    output logic [1:0]           o_ctrl_state,
    output logic [PERF_W-1:0]    o_stall_cycles
);

    // Wide enough to hold MDU_TIMEOUT-1 even when MDU_TIMEOUT is 1.
    localparam int unsigned WDOG_W = $clog2(MDU_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitAck = 2'd1,
        StBusy    = 2'd2,
        StDone    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WDOG_W-1:0]   r_wdog;
    logic [WDOG_W-1:0]   w_wdog_next;
    logic                r_timeout_err;
    logic                w_timeout_set;
    logic [PERF_W-1:0]   r_stall_cycles;

    logic w_mem_bp;
    logic w_branch;
    logic w_load_use;
    logic w_wdog_hit;

    assign w_mem_bp   = i_ex2_valid & ~i_mem_ready;
    // Only reached when backpressure is absent, so stall_ex2=0 is implied.
    assign w_branch   = i_ex2_valid & i_ex2_branch_taken;
    assign w_load_use = i_ex1_valid & i_ex2_valid & i_ex2_write_gpr & i_ex2_mem_to_reg &
                        (i_ex2_rd != '0) &
                        ((i_ex1_use_rs1 & (i_ex1_rs1 == i_ex2_rd)) |
                         (i_ex1_use_rs2 & (i_ex1_rs2 == i_ex2_rd)));
    assign w_wdog_hit = (r_wdog == WDOG_W'(MDU_TIMEOUT - 1));

    assign o_ctrl_state      = r_state;
    assign o_mdu_timeout_err = r_timeout_err;
    assign o_stall_cycles    = r_stall_cycles;

    // Prioritised hazard resolution and FSM next-state / watchdog next value.
    always_comb begin
        o_stall_if_id = 1'b0;
        o_stall_ex1   = 1'b0;
        o_stall_ex2   = 1'b0;
        o_flush_ex1   = 1'b0;
        o_flush_id    = 1'b0;
        o_mdu_start   = 1'b0;
        o_mdu_kill    = 1'b0;
        w_next_state  = r_state;
        w_wdog_next   = '0;
        w_timeout_set = 1'b0;

        if (rst) begin
            w_next_state = StIdle;
        end else if (w_mem_bp) begin
            o_stall_if_id = 1'b1;
            o_stall_ex1   = 1'b1;
            o_stall_ex2   = 1'b1;
            // Only a completing MDU may move the FSM while the segment is frozen.
            if (r_state == StBusy) begin
                if (i_mdu_done) begin
                    w_next_state = StDone;
                end else begin
                    w_wdog_next = r_wdog;
                end
            end
        end else if (w_branch) begin
            o_flush_ex1 = 1'b1;
            o_flush_id  = 1'b1;
            // The MDU op sits in EX1, younger than the branch: abandon it.
            if (r_state != StIdle) begin
                o_mdu_kill   = 1'b1;
                w_next_state = StIdle;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_ex1_valid && i_ex1_is_mdu) begin
                        o_mdu_start   = 1'b1;
                        o_stall_ex1   = 1'b1;
                        o_stall_if_id = 1'b1;
                        o_flush_ex1   = 1'b1;
                        w_next_state  = i_mdu_ready ? StBusy : StWaitAck;
                    end else if (w_load_use) begin
                        o_stall_ex1   = 1'b1;
                        o_stall_if_id = 1'b1;
                        o_flush_ex1   = 1'b1;
                    end
                end
                StWaitAck: begin
                    o_mdu_start   = 1'b1;
                    o_stall_ex1   = 1'b1;
                    o_stall_if_id = 1'b1;
                    o_flush_ex1   = 1'b1;
                    if (i_mdu_ready) begin
                        w_next_state = StBusy;
                    end
                end
                StBusy: begin
                    o_stall_ex1   = 1'b1;
                    o_stall_if_id = 1'b1;
                    o_flush_ex1   = 1'b1;
                    if (i_mdu_done) begin
                        w_next_state = StDone;
                    end else if (w_wdog_hit) begin
                        o_mdu_kill    = 1'b1;
                        w_timeout_set = 1'b1;
                        w_next_state  = StDone;
                    end else begin
                        w_wdog_next = r_wdog + 1'b1;
                    end
                end
                StDone: begin
                    // Result is written back; EX1 moves on without re-checking start.
                    w_next_state = StIdle;
                end
                default: begin
                    w_next_state = StIdle;
                end
            endcase
        end
    end

    // State, watchdog, sticky error and saturating stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_wdog         <= '0;
            r_timeout_err  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_next_state;
            r_wdog  <= w_wdog_next;
            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end
            if (o_stall_ex1 && (r_stall_cycles != {PERF_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exu_pipe_ctrl.sv
// Self-checking bench for exu_pipe_ctrl: vector table plus multi-cycle sequences,
// expected values queued at drive time and compared on the falling edge.
module tb_exu_pipe_ctrl;

    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned MDU_TIMEOUT = 8;
    localparam int unsigned PERF_W      = 4;

    typedef struct packed {
        logic       ex1_valid;
        logic       ex1_is_mdu;
        logic       use_rs1;
        logic       use_rs2;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       ex2_valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
        logic       mem_ready;
        logic       mdu_ready;
        logic       mdu_done;
    } in_t;

    // Bit order: stall_if_id, stall_ex1, stall_ex2, flush_ex1, flush_id, start, kill, err
    typedef struct packed {
        logic [7:0] flags;
        logic [1:0] st;
    } out_t;

    typedef struct {
        out_t       exp;
        logic       chk_cnt;
        logic [3:0] cnt;
        string      name;
    } sb_t;

    typedef struct {
        in_t   vin;
        out_t  exp;
        string name;
    } vec_t;

    localparam logic [7:0] NONE    = 8'b0000_0000;
    localparam logic [7:0] HOLD    = 8'b1101_0000;
    localparam logic [7:0] BP      = 8'b1110_0000;
    localparam logic [7:0] BR      = 8'b0001_1000;
    localparam logic [7:0] MDU_ST  = 8'b1101_0100;
    localparam logic [7:0] BR_KILL = 8'b0001_1010;
    localparam logic [7:0] WD_KILL = 8'b1101_0010;
    localparam logic [7:0] ERR     = 8'b0000_0001;

    logic                 clk;
    logic                 rst;
    logic                 ex1_valid, ex1_is_mdu, ex1_use_rs1, ex1_use_rs2;
    logic [REG_IDX_W-1:0] ex1_rs1, ex1_rs2, ex2_rd;
    logic                 ex2_valid, ex2_write_gpr, ex2_mem_to_reg, ex2_branch_taken;
    logic                 mem_ready, mdu_ready, mdu_done;
    logic                 stall_if_id, stall_ex1, stall_ex2, flush_ex1, flush_id;
    logic                 mdu_start, mdu_kill, mdu_timeout_err;
    logic [1:0]           ctrl_state;
    logic [PERF_W-1:0]    stall_cycles;

    exu_pipe_ctrl #(
        .REG_IDX_W  (REG_IDX_W),
        .MDU_TIMEOUT(MDU_TIMEOUT),
        .PERF_W     (PERF_W)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .i_ex1_valid       (ex1_valid),
        .i_ex1_is_mdu      (ex1_is_mdu),
        .i_ex1_use_rs1     (ex1_use_rs1),
        .i_ex1_use_rs2     (ex1_use_rs2),
        .i_ex1_rs1         (ex1_rs1),
        .i_ex1_rs2         (ex1_rs2),
        .i_ex2_valid       (ex2_valid),
        .i_ex2_rd          (ex2_rd),
        .i_ex2_write_gpr   (ex2_write_gpr),
        .i_ex2_mem_to_reg  (ex2_mem_to_reg),
        .i_ex2_branch_taken(ex2_branch_taken),
        .i_mem_ready       (mem_ready),
        .i_mdu_ready       (mdu_ready),
        .i_mdu_done        (mdu_done),
        .o_stall_if_id     (stall_if_id),
        .o_stall_ex1       (stall_ex1),
        .o_stall_ex2       (stall_ex2),
        .o_flush_ex1       (flush_ex1),
        .o_flush_id        (flush_id),
        .o_mdu_start       (mdu_start),
        .o_mdu_kill        (mdu_kill),
        .o_mdu_timeout_err (mdu_timeout_err),
        .o_ctrl_state      (ctrl_state),
        .o_stall_cycles    (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    sb_t  cur;
    out_t got;

    function automatic in_t mk_in(input logic e1v, input logic mdu, input logic u1,
                                  input logic u2, input logic [4:0] r1, input logic [4:0] r2,
                                  input logic e2v, input logic [4:0] rd, input logic wr,
                                  input logic ld, input logic br, input logic mrdy,
                                  input logic drdy, input logic done);
        in_t v;
        v.ex1_valid = e1v; v.ex1_is_mdu = mdu; v.use_rs1 = u1; v.use_rs2 = u2;
        v.rs1 = r1; v.rs2 = r2; v.ex2_valid = e2v; v.rd = rd; v.wr = wr; v.ld = ld;
        v.br = br; v.mem_ready = mrdy; v.mdu_ready = drdy; v.mdu_done = done;
        return v;
    endfunction

    function automatic out_t mk_out(input logic [7:0] f, input logic [1:0] st);
        out_t o;
        o.flags = f;
        o.st    = st;
        return o;
    endfunction

    function automatic in_t idle_in();
        return mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endfunction

    function automatic in_t mdu_in(input logic drdy, input logic done);
        return mk_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, drdy, done);
    endfunction

    function automatic in_t br_in(input logic mrdy);
        return mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, mrdy, 0, 0);
    endfunction

    task automatic apply(input in_t v);
        ex1_valid = v.ex1_valid; ex1_is_mdu = v.ex1_is_mdu;
        ex1_use_rs1 = v.use_rs1; ex1_use_rs2 = v.use_rs2;
        ex1_rs1 = v.rs1; ex1_rs2 = v.rs2;
        ex2_valid = v.ex2_valid; ex2_rd = v.rd; ex2_write_gpr = v.wr;
        ex2_mem_to_reg = v.ld; ex2_branch_taken = v.br;
        mem_ready = v.mem_ready; mdu_ready = v.mdu_ready; mdu_done = v.mdu_done;
    endtask

    task automatic push(input out_t e, input logic chk, input logic [3:0] cnt,
                        input string nm);
        sb_t s;
        s.exp = e; s.chk_cnt = chk; s.cnt = cnt; s.name = nm;
        sb_q.push_back(s);
    endtask

    task automatic drive(input in_t v, input out_t e, input logic chk,
                         input logic [3:0] cnt, input string nm);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(v);
        push(e, chk, cnt, nm);
    endtask

    task automatic drive_rst(input in_t v, input out_t e, input logic chk,
                             input logic [3:0] cnt, input string nm);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(v);
        push(e, chk, cnt, nm);
    endtask

    task automatic reset_quiet(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            apply(idle_in());
        end
    endtask

    // Scoreboard: each queued expectation belongs to the cycle it was driven in.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            got = {stall_if_id, stall_ex1, stall_ex2, flush_ex1, flush_id,
                   mdu_start, mdu_kill, mdu_timeout_err, ctrl_state};
            n_checks++;
            if (got === cur.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got flags=%b state=%0d, expected flags=%b state=%0d",
                         cur.name, got.flags, got.st, cur.exp.flags, cur.exp.st);
            end
            if (cur.chk_cnt) begin
                n_checks++;
                if (stall_cycles === cur.cnt) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s stall_cycles: got %0d expected %0d",
                             cur.name, stall_cycles, cur.cnt);
                end
            end
        end
    end

    vec_t vecs[15];

    initial begin
        rst = 1'b1;
        apply(mdu_in(1, 0));

        vecs[0]  = '{mk_in(1,0,1,0,5,0, 1,5,1,1,0,1,0,0), mk_out(HOLD, 0), "lu_rs1"};
        vecs[1]  = '{mk_in(1,0,1,0,0,0, 1,0,1,1,0,1,0,0), mk_out(NONE, 0), "lu_rd0"};
        vecs[2]  = '{mk_in(1,0,0,1,3,7, 1,7,1,1,0,1,0,0), mk_out(HOLD, 0), "lu_rs2"};
        vecs[3]  = '{mk_in(1,0,1,0,3,7, 1,7,1,1,0,1,0,0), mk_out(NONE, 0), "lu_rs2_unused"};
        vecs[4]  = '{mk_in(0,0,1,0,5,0, 1,5,1,1,0,1,0,0), mk_out(NONE, 0), "lu_ex1_invalid"};
        vecs[5]  = '{mk_in(1,0,1,0,5,0, 1,5,1,0,0,1,0,0), mk_out(NONE, 0), "lu_not_load"};
        vecs[6]  = '{mk_in(1,0,1,0,5,0, 1,5,0,1,0,1,0,0), mk_out(NONE, 0), "lu_no_write"};
        vecs[7]  = '{mk_in(1,0,1,0,5,0, 0,5,1,1,0,1,0,0), mk_out(NONE, 0), "lu_ex2_invalid"};
        vecs[8]  = '{mk_in(1,0,1,0,5,0, 1,5,1,1,0,0,0,0), mk_out(BP, 0),   "bp_over_lu"};
        vecs[9]  = '{br_in(1),                            mk_out(BR, 0),   "branch"};
        vecs[10] = '{br_in(0),                            mk_out(BP, 0),   "bp_over_branch"};
        vecs[11] = '{mk_in(1,0,1,0,5,0, 1,5,1,1,1,1,0,0), mk_out(BR, 0),   "branch_over_lu"};
        vecs[12] = '{mk_in(0,1,0,0,0,0, 0,0,0,0,0,1,1,0), mk_out(NONE, 0), "mdu_ex1_invalid"};
        vecs[13] = '{mk_in(1,1,0,0,0,0, 1,0,0,0,1,1,1,0), mk_out(BR, 0),   "branch_over_mdu"};
        vecs[14] = '{mk_in(1,1,0,0,0,0, 1,0,0,0,0,0,1,0), mk_out(BP, 0),   "bp_over_mdu"};

        // Outputs are forced low while reset is held, even with an MDU op presented.
        drive_rst(mdu_in(1, 0), mk_out(NONE, 0), 1, 0, "reset_state");

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].vin, vecs[i].exp, 0, 0, vecs[i].name);
        end

        // Load-use: exactly one bubble, then the load has left EX2.
        reset_quiet(2);
        drive(mk_in(1,0,1,0,5,0, 1,5,1,1,0,1,0,0), mk_out(HOLD, 0), 0, 0, "lu_bubble");
        drive(mk_in(1,0,1,0,5,0, 0,0,0,0,0,1,0,0), mk_out(NONE, 0), 1, 1, "lu_release");

        // MDU nominal: ready immediately, done four cycles after start.
        reset_quiet(2);
        drive(mdu_in(1, 0), mk_out(MDU_ST, 0), 0, 0, "mdu_nom_start");
        repeat (3) drive(mdu_in(0, 0), mk_out(HOLD, 2), 0, 0, "mdu_nom_busy");
        drive(mdu_in(0, 1), mk_out(HOLD, 2), 0, 0, "mdu_nom_done_in");
        drive(mdu_in(0, 0), mk_out(NONE, 3), 1, 5, "mdu_nom_done");
        drive(idle_in(),    mk_out(NONE, 0), 1, 5, "mdu_nom_idle");

        // Handshake: ready low for three WAIT_ACK cycles, then branch kills the BUSY op.
        reset_quiet(2);
        drive(mdu_in(0, 0), mk_out(MDU_ST, 0), 0, 0, "hs_start");
        repeat (3) drive(mdu_in(0, 0), mk_out(MDU_ST, 1), 0, 0, "hs_wait");
        drive(mdu_in(1, 0), mk_out(MDU_ST, 1), 0, 0, "hs_ack");
        drive(mdu_in(0, 0), mk_out(HOLD, 2), 0, 0, "hs_busy");
        drive(mk_in(1,1,0,0,0,0, 1,0,0,0,1,1,0,0), mk_out(BR_KILL, 2), 0, 0, "br_kill");
        drive(idle_in(), mk_out(NONE, 0), 1, 6, "br_kill_idle");

        // Backpressure holds off the redirect until mem_ready rises.
        drive(br_in(0), mk_out(BP, 0), 0, 0, "bp_br_hold0");
        drive(br_in(0), mk_out(BP, 0), 0, 0, "bp_br_hold1");
        drive(br_in(1), mk_out(BR, 0), 0, 0, "bp_br_release");
        drive(idle_in(), mk_out(NONE, 0), 0, 0, "bp_br_idle");

        // Reset while BUSY: outputs low with no kill, state clears on the edge.
        reset_quiet(2);
        drive(mdu_in(1, 0), mk_out(MDU_ST, 0), 0, 0, "rmid_start");
        drive(mdu_in(0, 0), mk_out(HOLD, 2), 0, 0, "rmid_busy");
        drive_rst(mdu_in(0, 0), mk_out(NONE, 2), 0, 0, "rmid_rst");
        drive(idle_in(), mk_out(NONE, 0), 1, 0, "rmid_idle");

        // Watchdog: no done, kill on the eighth BUSY cycle, sticky error until reset.
        reset_quiet(2);
        drive(mdu_in(1, 0), mk_out(MDU_ST, 0), 0, 0, "wd_start");
        repeat (7) drive(mdu_in(0, 0), mk_out(HOLD, 2), 0, 0, "wd_busy");
        drive(mdu_in(0, 0), mk_out(WD_KILL, 2), 0, 0, "wd_kill");
        drive(idle_in(), mk_out(ERR, 3), 1, 9, "wd_done");
        drive(idle_in(), mk_out(ERR, 0), 0, 0, "wd_idle");
        drive(idle_in(), mk_out(ERR, 0), 0, 0, "wd_sticky");
        reset_quiet(1);
        drive_rst(idle_in(), mk_out(NONE, 0), 1, 0, "wd_rst_clears");
        drive(idle_in(), mk_out(NONE, 0), 0, 0, "wd_after_rst");

        // Stall counter saturates at all-ones instead of wrapping.
        reset_quiet(2);
        repeat (16) drive(br_in(0), mk_out(BP, 0), 0, 0, "sat_bp");
        drive(br_in(0), mk_out(BP, 0), 1, 15, "sat_16");
        drive(idle_in(), mk_out(NONE, 0), 1, 15, "sat_17");

        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exu_pipe_ctrl.md
Name: exu_pipe_ctrl

Overview:
Hazard and sequencing controller for the EX1->EX2 mini-pipeline segment and the multi-cycle MDU attached to EX1.
- Generates the EX2 segment hold (stall_ex2) and the bubble-insert (flush_ex1) that the segment register consumes.
- Generates the upstream IF/ID stall and flush.
- Sequences MDU start/kill with a watchdog.
- Keeps a stall-cycle performance counter.
- Sits beside the EXU segment register; pure control, no datapath.

Parameters:
REG_IDX_W, 5, GPR index width
MDU_TIMEOUT, 64, max cycles in MDU_BUSY before forced completion
PERF_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ex1_valid  in  1  EX1 holds a real instruction
ex1_is_mdu  in  1  EX1 instruction is mul/div
ex1_use_rs1  in  1  EX1 reads rs1
ex1_use_rs2  in  1  EX1 reads rs2
ex1_rs1  in  REG_IDX_W  EX1 source 1
ex1_rs2  in  REG_IDX_W  EX1 source 2
ex2_valid  in  1  EX2 holds a real instruction
ex2_rd  in  REG_IDX_W  EX2 destination
ex2_write_gpr  in  1  EX2 writes GPR
ex2_mem_to_reg  in  1  EX2 is a load
ex2_branch_taken  in  1  EX2 resolved a redirect
mem_ready  in  1  downstream accepts EX2 this cycle
mdu_ready  in  1  MDU accepts start
mdu_done  in  1  MDU result valid (1-cycle pulse)
stall_if_id  out  1  hold IF/ID
stall_ex1  out  1  hold EX1 register
stall_ex2  out  1  hold EX1->EX2 segment
flush_ex1  out  1  load bubble into EX2 (honoured only when stall_ex2=0)
flush_id  out  1  squash IF/ID contents
mdu_start  out  1  start MDU op
mdu_kill  out  1  abort in-flight MDU op
mdu_timeout_err  out  1  sticky watchdog error
ctrl_state  out  2  FSM state
stall_cycles  out  PERF_W  count of cycles with stall_ex1=1

Behaviour:
- FSM states: IDLE=0, WAIT_ACK=1, BUSY=2, DONE=3. Registered; all other outputs combinational from state and inputs, except mdu_timeout_err, the watchdog counter and stall_cycles, which are registered.
- Reset: state=IDLE, watchdog=0, mdu_timeout_err=0, stall_cycles=0. While rst=1, all combinational outputs are 0.
- Priority: rst > mem backpressure > branch redirect > MDU sequencing > load-use.
- Mem backpressure (ex2_valid & ~mem_ready):
  - stall_ex2=stall_ex1=stall_if_id=1; flush_ex1=flush_id=0.
  - FSM holds, except BUSY may still advance to DONE on mdu_done.
- Branch (ex2_valid & ex2_branch_taken & ~stall_ex2): flush_ex1=1, flush_id=1 for exactly that cycle.
  - If FSM is in WAIT_ACK/BUSY/DONE: mdu_kill=1 and next state=IDLE. The EX1 op is younger, so it is squashed.
- MDU sequencing:
  - IDLE & ex1_valid & ex1_is_mdu & no higher event: mdu_start=1, stall_ex1=stall_if_id=1, flush_ex1=1 (bubble to EX2). Next state = mdu_ready ? BUSY : WAIT_ACK.
  - WAIT_ACK: mdu_start=1, same stalls/bubble; go to BUSY on mdu_ready.
  - BUSY: stall_ex1=stall_if_id=1, flush_ex1=1; watchdog increments each cycle.
    - mdu_done -> DONE, watchdog cleared.
    - Watchdog==MDU_TIMEOUT-1 without done -> set mdu_timeout_err, mdu_kill=1, go to DONE.
  - DONE: one cycle with no stall and no flush; EX1 advances into EX2; next state=IDLE. The start check is not re-evaluated in DONE.
- Load-use (FSM in IDLE, no higher event): ex2_valid & ex2_write_gpr & ex2_mem_to_reg & ex2_rd!=0 & ((ex1_use_rs1 & ex1_rs1==ex2_rd) | (ex1_use_rs2 & ex1_rs2==ex2_rd)) & ex1_valid.
  - Response: stall_ex1=stall_if_id=1, flush_ex1=1, stall_ex2=0.
  - Exactly one bubble per load.
- ex1_valid=0: no MDU start, no load-use stall.
- stall_cycles increments when stall_ex1=1 and saturates at all-ones.
- Reset mid-operation: state returns to IDLE next edge. mdu_kill is not asserted during reset; the MDU shares rst.

Test Plan:
- Load-use: EX2 load with rd=5; EX1 with use_rs1=1, rs1=5 -> one cycle stall_ex1=1, flush_ex1=1, stall_ex2=0; next cycle no stall. Same stimulus with rd=0 -> no stall.
- MDU nominal: ex1_is_mdu=1, mdu_ready=1, mdu_done 4 cycles later -> mdu_start for 1 cycle; states 0,2,2,2,2,3,0; stall_ex1 high for 5 cycles; stall_cycles=5.
- MDU handshake: mdu_ready low 3 cycles -> WAIT_ACK for 3 cycles with mdu_start held; then BUSY.
- Branch kill: FSM in BUSY, ex2_branch_taken=1 -> same cycle flush_ex1=flush_id=mdu_kill=1; next state IDLE.
- Backpressure vs branch: mem_ready=0 with ex2_branch_taken=1 -> stall_ex2=1, flush_ex1=0. When mem_ready rises -> flush_ex1=flush_id=1 that cycle.
- Watchdog: MDU_TIMEOUT=8, mdu_done never arrives -> after 8 BUSY cycles mdu_timeout_err=1 (sticky), mdu_kill pulse, DONE, then IDLE. Assert rst -> err clears.
